axi4_burst_master: RTL and testbench



---
 rtl/axi4_burst_master.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_axi4_burst_master.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_burst_master.sv
// AXI4 master burst engine for the DMA subsystem.
// Splits one byte-granular read or write command into INCR bursts capped by
// MAX_BEATS and 4 KB pages, masks the partial first/last beats, and streams
// data between the user valid/ready port and the AXI4 channels.
module axi4_burst_master #(
   parameter int ID_WIDTH   = 4,
   parameter int DWIDTH     = 64,
   parameter int ADDR_WIDTH = 32,
   parameter int MAX_BEATS  = 16,
   parameter int LEN_WIDTH  = 16
) (
   input  logic                  ACLK,
   input  logic                  ARESET,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [LEN_WIDTH-1:0]  cmd_bytes,
   input  logic [ID_WIDTH-1:0]   cmd_id,
   input  logic [DWIDTH-1:0]     wr_data,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   output logic [DWIDTH-1:0]     rd_data,
   output logic [DWIDTH/8-1:0]   rd_strb,
   output logic                  rd_last,
   output logic                  rd_valid,
   input  logic                  rd_ready,
   output logic                  done,
   output logic [1:0]            done_resp,
   output logic [ID_WIDTH-1:0]   AWID,
   output logic [ADDR_WIDTH-1:0] AWADDR,
   output logic [7:0]            AWLEN,
   output logic [2:0]            AWSIZE,
   output logic [1:0]            AWBURST,
   output logic                  AWVALID,
   input  logic                  AWREADY,
   output logic [DWIDTH-1:0]     WDATA,
   output logic [DWIDTH/8-1:0]   WSTRB,
   output logic                  WLAST,
   output logic                  WVALID,
   input  logic                  WREADY,
   input  logic [ID_WIDTH-1:0]   BID,
   input  logic [1:0]            BRESP,
   input  logic                  BVALID,
   output logic                  BREADY,
   output logic [ID_WIDTH-1:0]   ARID,
   output logic [ADDR_WIDTH-1:0] ARADDR,
   output logic [7:0]            ARLEN,
   output logic [2:0]            ARSIZE,
   output logic [1:0]            ARBURST,
   output logic                  ARVALID,
   input  logic                  ARREADY,
   input  logic [ID_WIDTH-1:0]   RID,
   input  logic [DWIDTH-1:0]     RDATA,
   input  logic [1:0]            RRESP,
   input  logic                  RLAST,
   input  logic                  RVALID,
   output logic                  RREADY
);

   localparam int NB = DWIDTH / 8;
   localparam int SZ = $clog2(NB);
   localparam logic [2:0]            AX_SIZE  = 3'(SZ);
   localparam logic [1:0]            INCR     = 2'b01;
   localparam logic [ADDR_WIDTH-1:0] PAGE     = ADDR_WIDTH'(4096);
   localparam logic [NB-1:0]         ALL_ONES = '1;

   typedef enum logic [2:0] {
      S_IDLE, S_CALC, S_ADDR, S_WDATA, S_BRESP, S_RDATA, S_NEXT, S_DONE
   } state_t;

   state_t                state_q, state_d;
   logic                  cmd_ready_q, cmd_ready_d;
   logic                  awvalid_q, awvalid_d;
   logic                  arvalid_q, arvalid_d;
   logic                  bready_q, bready_d;
   logic                  done_q, done_d;
   logic [1:0]            done_resp_q, done_resp_d;
   logic [ADDR_WIDTH-1:0] ax_addr_q, ax_addr_d;
   logic [7:0]            ax_len_q, ax_len_d;
   logic [ID_WIDTH-1:0]   id_q, id_d;
   logic                  write_q, write_d;
   logic [ADDR_WIDTH-1:0] cur_q, cur_d;
   logic [ADDR_WIDTH-1:0] end_q, end_d;
   logic [SZ-1:0]         start_off_q, start_off_d;
   logic [7:0]            beat_q, beat_d;
   logic                  first_q, first_d;
   logic [1:0]            resp_q, resp_d;

   logic [ADDR_WIDTH-1:0] cur_word, end_word, beat_word;
   logic [ADDR_WIDTH-1:0] beats_rem, beats_4k, beats_sel, page_off;
   logic [ADDR_WIDTH:0]   next_word;
   logic                  burst_last, cmd_last_beat, in_w, in_r;
   logic [NB-1:0]         strb_mask;
   logic                  unused_ids;

   assign unused_ids = ^{BID, RID};

   // Keeps the first error seen; EXOKAY only replaces a clean OKAY.
   function automatic logic [1:0] fold_resp(input logic [1:0] acc, input logic [1:0] resp);
      if (acc[1])
         return acc;
      if (resp[1] || acc == 2'b00)
         return resp;
      return acc;
   endfunction

   // Burst sizing, beat position and byte-lane masking for the current beat.
   always_comb begin
      cur_word      = cur_q >> SZ;
      end_word      = end_q >> SZ;
      beats_rem     = end_word - cur_word + ADDR_WIDTH'(1);
      page_off      = ADDR_WIDTH'({cur_q[11:SZ], {SZ{1'b0}}});
      beats_4k      = (PAGE - page_off) >> SZ;
      beats_sel     = ADDR_WIDTH'(MAX_BEATS);
      if (beats_4k < beats_sel)
         beats_sel = beats_4k;
      if (beats_rem < beats_sel)
         beats_sel = beats_rem;
      beat_word     = cur_word + ADDR_WIDTH'(beat_q);
      cmd_last_beat = (beat_word == end_word);
      burst_last    = (beat_q == ax_len_q);
      next_word     = {1'b0, cur_word} + (ADDR_WIDTH+1)'(ax_len_q) + (ADDR_WIDTH+1)'(1);
      strb_mask     = ALL_ONES;
      if (first_q)
         strb_mask = strb_mask & (ALL_ONES << start_off_q);
      if (cmd_last_beat)
         strb_mask = strb_mask & (ALL_ONES >> (SZ'(NB - 1) - end_q[SZ-1:0]));
   end

   // Next-state and datapath update; the registered outputs follow the next state.
   always_comb begin
      state_d     = state_q;
      write_d     = write_q;
      id_d        = id_q;
      cur_d       = cur_q;
      end_d       = end_q;
      start_off_d = start_off_q;
      ax_addr_d   = ax_addr_q;
      ax_len_d    = ax_len_q;
      beat_d      = beat_q;
      first_d     = first_q;
      resp_d      = resp_q;
      case (state_q)
         S_IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               write_d     = cmd_write;
               id_d        = cmd_id;
               cur_d       = cmd_addr;
               end_d       = cmd_addr + ADDR_WIDTH'(cmd_bytes) - ADDR_WIDTH'(1);
               start_off_d = cmd_addr[SZ-1:0];
               first_d     = 1'b1;
               resp_d      = 2'b00;
               state_d     = (cmd_bytes == '0) ? S_DONE : S_CALC;
            end
         end
         S_CALC: begin
            ax_addr_d = cur_q;
            ax_len_d  = beats_sel[7:0] - 8'd1;
            beat_d    = 8'd0;
            state_d   = S_ADDR;
         end
         S_ADDR: begin
            if ((awvalid_q && AWREADY) || (arvalid_q && ARREADY))
               state_d = write_q ? S_WDATA : S_RDATA;
         end
         S_WDATA: begin
            if (wr_valid && WREADY) begin
               beat_d  = beat_q + 8'd1;
               first_d = 1'b0;
               if (burst_last)
                  state_d = S_BRESP;
            end
         end
         S_BRESP: begin
            if (bready_q && BVALID) begin
               resp_d  = fold_resp(resp_q, BRESP);
               state_d = S_NEXT;
            end
         end
         S_RDATA: begin
            if (RVALID && rd_ready) begin
               resp_d = fold_resp(resp_q, RRESP);
               if (RLAST != burst_last)
                  resp_d = 2'b10;
               beat_d  = beat_q + 8'd1;
               first_d = 1'b0;
               if (burst_last)
                  state_d = S_NEXT;
            end
         end
         S_NEXT: begin
            cur_d   = next_word[ADDR_WIDTH-1:0] << SZ;
            state_d = (next_word > {1'b0, end_word}) ? S_DONE : S_CALC;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      cmd_ready_d = (state_d == S_IDLE);
      awvalid_d   = (state_d == S_ADDR) && write_d;
      arvalid_d   = (state_d == S_ADDR) && !write_d;
      bready_d    = (state_d == S_BRESP);
      done_d      = (state_q == S_DONE);
      done_resp_d = (state_q == S_DONE) ? resp_q : 2'b00;
   end

   // State and registered outputs; reset abandons any command in flight.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state_q     <= S_IDLE;
         cmd_ready_q <= 1'b0;
         awvalid_q   <= 1'b0;
         arvalid_q   <= 1'b0;
         bready_q    <= 1'b0;
         done_q      <= 1'b0;
         done_resp_q <= 2'b00;
         ax_addr_q   <= '0;
         ax_len_q    <= 8'd0;
         id_q        <= '0;
         write_q     <= 1'b0;
         cur_q       <= '0;
         end_q       <= '0;
         start_off_q <= '0;
         beat_q      <= 8'd0;
         first_q     <= 1'b0;
         resp_q      <= 2'b00;
      end else begin
         state_q     <= state_d;
         cmd_ready_q <= cmd_ready_d;
         awvalid_q   <= awvalid_d;
         arvalid_q   <= arvalid_d;
         bready_q    <= bready_d;
         done_q      <= done_d;
         done_resp_q <= done_resp_d;
         ax_addr_q   <= ax_addr_d;
         ax_len_q    <= ax_len_d;
         id_q        <= id_d;
         write_q     <= write_d;
         cur_q       <= cur_d;
         end_q       <= end_d;
         start_off_q <= start_off_d;
         beat_q      <= beat_d;
         first_q     <= first_d;
         resp_q      <= resp_d;
      end
   end

   assign in_w      = (state_q == S_WDATA);
   assign in_r      = (state_q == S_RDATA);
   assign cmd_ready = cmd_ready_q;
   assign done      = done_q;
   assign done_resp = done_resp_q;
   assign AWID      = id_q;
   assign AWADDR    = ax_addr_q;
   assign AWLEN     = ax_len_q;
   assign AWSIZE    = awvalid_q ? AX_SIZE : 3'd0;
   assign AWBURST   = awvalid_q ? INCR : 2'b00;
   assign AWVALID   = awvalid_q;
   assign ARID      = id_q;
   assign ARADDR    = ax_addr_q;
   assign ARLEN     = ax_len_q;
   assign ARSIZE    = arvalid_q ? AX_SIZE : 3'd0;
   assign ARBURST   = arvalid_q ? INCR : 2'b00;
   assign ARVALID   = arvalid_q;
   assign BREADY    = bready_q;
   assign WVALID    = in_w && wr_valid;
   assign wr_ready  = in_w && WREADY;
   assign WDATA     = in_w ? wr_data : '0;
   assign WSTRB     = in_w ? strb_mask : '0;
   assign WLAST     = in_w && burst_last;
   assign rd_valid  = in_r && RVALID;
   assign RREADY    = in_r && rd_ready;
   assign rd_data   = in_r ? RDATA : '0;
   assign rd_strb   = in_r ? strb_mask : '0;
   assign rd_last   = in_r && cmd_last_beat;

endmodule

// File: tb/tb_axi4_burst_master.sv
// Scoreboard bench for axi4_burst_master: tests queue expected AW/AR/W/read/done
// records, a monitor pops and compares them on every DUT handshake.
module tb_axi4_burst_master;

   localparam int ID_WIDTH   = 4;
   localparam int DWIDTH     = 64;
   localparam int ADDR_WIDTH = 32;
   localparam int MAX_BEATS  = 16;
   localparam int LEN_WIDTH  = 16;

   logic                  ACLK;
   logic                  ARESET;
   logic                  cmd_valid, cmd_ready, cmd_write;
   logic [ADDR_WIDTH-1:0] cmd_addr;
   logic [LEN_WIDTH-1:0]  cmd_bytes;
   logic [ID_WIDTH-1:0]   cmd_id;
   logic [DWIDTH-1:0]     wr_data;
   logic                  wr_valid, wr_ready;
   logic [DWIDTH-1:0]     rd_data;
   logic [7:0]            rd_strb;
   logic                  rd_last, rd_valid, rd_ready;
   logic                  done;
   logic [1:0]            done_resp;
   logic [ID_WIDTH-1:0]   AWID, ARID, BID, RID;
   logic [ADDR_WIDTH-1:0] AWADDR, ARADDR;
   logic [7:0]            AWLEN, ARLEN;
   logic [2:0]            AWSIZE, ARSIZE;
   logic [1:0]            AWBURST, ARBURST, BRESP, RRESP;
   logic                  AWVALID, AWREADY, ARVALID, ARREADY;
   logic [DWIDTH-1:0]     WDATA, RDATA;
   logic [7:0]            WSTRB;
   logic                  WLAST, WVALID, WREADY;
   logic                  BVALID, BREADY;
   logic                  RLAST, RVALID, RREADY;

   int testsRun    = 0;
   int testsFailed = 0;
   int wHsCount    = 0;
   int doneCount   = 0;
   logic toggleRd  = 1'b0;

   logic [43:0] expAw[$];
   logic [43:0] expAr[$];
   logic [8:0]  expW[$];
   logic [8:0]  expRd[$];
   logic [1:0]  expDone[$];
   logic [1:0]  bRespQ[$];

   axi4_burst_master #(
      .ID_WIDTH(ID_WIDTH), .DWIDTH(DWIDTH), .ADDR_WIDTH(ADDR_WIDTH),
      .MAX_BEATS(MAX_BEATS), .LEN_WIDTH(LEN_WIDTH)
   ) dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_bytes(cmd_bytes), .cmd_id(cmd_id),
      .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .rd_data(rd_data), .rd_strb(rd_strb), .rd_last(rd_last),
      .rd_valid(rd_valid), .rd_ready(rd_ready),
      .done(done), .done_resp(done_resp),
      .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
      .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
      .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
      .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
      .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
      .RVALID(RVALID), .RREADY(RREADY)
   );

   // Free-running 10-time-unit clock.
   initial begin
      ACLK = 1'b0;
      forever #5 ACLK = ~ACLK;
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Reports a handshake that no test asked for.
   task automatic flagUnexpected(input string name);
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL %s: got an unexpected handshake, expected none", name);
   endtask

   // Monitor: pops the scoreboard whenever the DUT completes a handshake.
   always @(negedge ACLK) begin : monitor
      logic [43:0] eAx;
      logic [8:0]  eBeat;
      logic [1:0]  eResp;
      if (!ARESET) begin
         if (AWVALID && AWREADY) begin
            if (expAw.size() == 0) flagUnexpected("aw");
            else begin
               eAx = expAw.pop_front();
               checkOutput("awId", 64'(AWID), 64'(eAx[43:40]));
               checkOutput("awAddr", 64'(AWADDR), 64'(eAx[39:8]));
               checkOutput("awLen", 64'(AWLEN), 64'(eAx[7:0]));
               checkOutput("awSizeBurst", 64'({AWSIZE, AWBURST}), 64'({3'd3, 2'b01}));
            end
         end
         if (ARVALID && ARREADY) begin
            if (expAr.size() == 0) flagUnexpected("ar");
            else begin
               eAx = expAr.pop_front();
               checkOutput("arId", 64'(ARID), 64'(eAx[43:40]));
               checkOutput("arAddr", 64'(ARADDR), 64'(eAx[39:8]));
               checkOutput("arLen", 64'(ARLEN), 64'(eAx[7:0]));
               checkOutput("arSizeBurst", 64'({ARSIZE, ARBURST}), 64'({3'd3, 2'b01}));
            end
         end
         if (WVALID && WREADY) begin
            wHsCount++;
            if (expW.size() == 0) flagUnexpected("w");
            else begin
               eBeat = expW.pop_front();
               checkOutput("wStrb", 64'(WSTRB), 64'(eBeat[8:1]));
               checkOutput("wLast", 64'(WLAST), 64'(eBeat[0]));
               checkOutput("wData", WDATA, wr_data);
               checkOutput("wrReady", 64'(wr_ready), 64'(1));
            end
         end
         if (rd_valid && rd_ready) begin
            if (expRd.size() == 0) flagUnexpected("rd");
            else begin
               eBeat = expRd.pop_front();
               checkOutput("rdStrb", 64'(rd_strb), 64'(eBeat[8:1]));
               checkOutput("rdLast", 64'(rd_last), 64'(eBeat[0]));
               checkOutput("rdData", rd_data, RDATA);
            end
         end
         if (done) begin
            doneCount++;
            if (expDone.size() == 0) flagUnexpected("done");
            else begin
               eResp = expDone.pop_front();
               checkOutput("doneResp", 64'(done_resp), 64'(eResp));
            end
         end
      end
   end

   // Slave model: always-ready AW/AR/W, one B per WLAST, R beats per AR.
   initial begin : slaveModel
      logic arHs, rHs, wHs, wLastHs, bHs, rst;
      logic [7:0] arLen;
      int rBeatsLeft;
      int rBeatIdx;
      rBeatsLeft = 0;
      rBeatIdx   = 0;
      forever begin
         @(negedge ACLK);
         rst     = ARESET;
         arHs    = ARVALID && ARREADY;
         arLen   = ARLEN;
         rHs     = RVALID && RREADY;
         wHs     = WVALID && WREADY;
         wLastHs = wHs && WLAST;
         bHs     = BVALID && BREADY;
         @(posedge ACLK);
         #1;
         if (toggleRd) rd_ready = ~rd_ready;
         else rd_ready = 1'b1;
         if (rst) begin
            rBeatsLeft = 0;
            RVALID = 1'b0;
            RLAST  = 1'b0;
            BVALID = 1'b0;
         end else begin
            if (wHs) wr_data = {$urandom, $urandom};
            if (bHs) BVALID = 1'b0;
            if (wLastHs) begin
               BVALID = 1'b1;
               BRESP  = 2'b00;
               if (bRespQ.size() > 0) BRESP = bRespQ.pop_front();
            end
            if (arHs) rBeatsLeft = int'(arLen) + 1;
            if (rHs) begin
               rBeatsLeft--;
               rBeatIdx++;
            end
            RVALID = (rBeatsLeft > 0);
            RLAST  = (rBeatsLeft == 1);
            RDATA  = {32'hCAFE_F00D, 32'(rBeatIdx)};
         end
      end
   end

   // Issues one command and waits (bounded) for its acceptance.
   task automatic applyStimulus(input logic write, input logic [31:0] addr, input logic [15:0] bytes, input logic [3:0] id);
      bit accepted;
      accepted = 1'b0;
      @(posedge ACLK);
      #1;
      cmd_valid = 1'b1;
      cmd_write = write;
      cmd_addr  = addr;
      cmd_bytes = bytes;
      cmd_id    = id;
      for (int i = 0; i < 50; i++) begin
         @(negedge ACLK);
         if (cmd_ready) begin
            accepted = 1'b1;
            break;
         end
      end
      @(posedge ACLK);
      #1;
      cmd_valid = 1'b0;
      if (!accepted) flagUnexpected("cmdAcceptTimeout");
   endtask

   // Waits (bounded) for the done pulse of the command just issued.
   task automatic waitDone(input int target);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(posedge ACLK);
         if (doneCount >= target) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         testsRun++;
         testsFailed++;
         $display("[TB] FAIL doneTimeout: got no done pulse, expected done #%0d", target);
      end
   endtask

   task automatic pushAx(input bit write, input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
      if (write) expAw.push_back({id, addr, len});
      else expAr.push_back({id, addr, len});
   endtask

   // Watchdog in case something escapes the bounded waits.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : mainSeq
      logic [15:0] outVec;
      int savedDone, startW;
      ARESET = 1'b1;
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_bytes = '0; cmd_id = '0;
      wr_data = 64'h0123_4567_89AB_CDEF; wr_valid = 1'b1; rd_ready = 1'b1;
      AWREADY = 1'b1; WREADY = 1'b1; ARREADY = 1'b1;
      BID = '0; BRESP = 2'b00; BVALID = 1'b0;
      RID = '0; RDATA = '0; RRESP = 2'b00; RLAST = 1'b0; RVALID = 1'b0;

      #3;
      outVec = {AWVALID, ARVALID, WVALID, WLAST, BREADY, RREADY, rd_valid, rd_last,
                cmd_ready, done, wr_ready, done_resp, 3'b000};
      checkOutput("resetOutputs", 64'(outVec), 64'd0);
      checkOutput("resetStrbData", 64'({WSTRB, rd_strb}), 64'd0);
      repeat (2) @(posedge ACLK);
      #1;
      ARESET = 1'b0;
      @(posedge ACLK);
      @(negedge ACLK);
      checkOutput("cmdReadyAfterReset", 64'(cmd_ready), 64'(1));

      $display("[TB] aligned write 0x1000 / 64 bytes");
      pushAx(1, 4'd1, 32'h1000, 8'd7);
      for (int i = 0; i < 8; i++) expW.push_back({8'hFF, i == 7});
      expDone.push_back(2'b00);
      applyStimulus(1'b1, 32'h1000, 16'd64, 4'd1);
      waitDone(1);

      $display("[TB] unaligned write 0x1003 / 10 bytes");
      pushAx(1, 4'd2, 32'h1003, 8'd1);
      expW.push_back({8'hF8, 1'b0});
      expW.push_back({8'h1F, 1'b1});
      expDone.push_back(2'b00);
      applyStimulus(1'b1, 32'h1003, 16'd10, 4'd2);
      waitDone(2);

      $display("[TB] 4 KB crossing read 0x0FF0 / 32 bytes, rd_ready toggling");
      pushAx(0, 4'd3, 32'h0FF0, 8'd1);
      pushAx(0, 4'd3, 32'h1000, 8'd1);
      for (int i = 0; i < 4; i++) expRd.push_back({8'hFF, i == 3});
      expDone.push_back(2'b00);
      toggleRd = 1'b1;
      applyStimulus(1'b0, 32'h0FF0, 16'd32, 4'd3);
      waitDone(3);
      toggleRd = 1'b0;

      $display("[TB] unaligned read 0x1003 / 10 bytes");
      pushAx(0, 4'd4, 32'h1003, 8'd1);
      expRd.push_back({8'hF8, 1'b0});
      expRd.push_back({8'h1F, 1'b1});
      expDone.push_back(2'b00);
      applyStimulus(1'b0, 32'h1003, 16'd10, 4'd4);
      waitDone(4);

      $display("[TB] max-length split write 0x2000 / 200 bytes");
      pushAx(1, 4'd6, 32'h2000, 8'd15);
      pushAx(1, 4'd6, 32'h2080, 8'd8);
      for (int i = 0; i < 25; i++) expW.push_back({8'hFF, (i == 15) || (i == 24)});
      expDone.push_back(2'b00);
      applyStimulus(1'b1, 32'h2000, 16'd200, 4'd6);
      waitDone(5);

      $display("[TB] error on first burst of split write");
      pushAx(1, 4'd7, 32'h2000, 8'd15);
      pushAx(1, 4'd7, 32'h2080, 8'd8);
      for (int i = 0; i < 25; i++) expW.push_back({8'hFF, (i == 15) || (i == 24)});
      bRespQ.push_back(2'b10);
      bRespQ.push_back(2'b00);
      expDone.push_back(2'b10);
      applyStimulus(1'b1, 32'h2000, 16'd200, 4'd7);
      waitDone(6);

      $display("[TB] zero-length command");
      expDone.push_back(2'b00);
      applyStimulus(1'b1, 32'h4000, 16'd0, 4'd8);
      @(negedge ACLK);
      checkOutput("zeroLenDoneCycle1", 64'(done), 64'(0));
      @(negedge ACLK);
      checkOutput("zeroLenDoneCycle2", 64'(done), 64'(1));
      waitDone(7);

      $display("[TB] reset during beat 3 of a 16-beat write");
      pushAx(1, 4'd5, 32'h3000, 8'd15);
      for (int i = 0; i < 16; i++) expW.push_back({8'hFF, i == 15});
      startW = wHsCount;
      applyStimulus(1'b1, 32'h3000, 16'd128, 4'd5);
      for (int i = 0; i < 100; i++) begin
         @(posedge ACLK);
         if (wHsCount - startW >= 2) break;
      end
      checkOutput("beatsBeforeReset", 64'(wHsCount - startW), 64'd2);
      #1;
      checkOutput("beat3Presented", 64'(WVALID), 64'(1));
      savedDone = doneCount;
      ARESET = 1'b1;
      #1;
      outVec = {AWVALID, ARVALID, WVALID, WLAST, BREADY, RREADY, rd_valid, rd_last,
                cmd_ready, done, wr_ready, done_resp, 3'b000};
      checkOutput("midResetOutputs", 64'(outVec), 64'd0);
      expW.delete();
      expAw.delete();
      repeat (2) @(posedge ACLK);
      #1;
      ARESET = 1'b0;
      @(posedge ACLK);
      @(negedge ACLK);
      checkOutput("cmdReadyAfterMidReset", 64'(cmd_ready), 64'(1));
      repeat (10) @(posedge ACLK);
      checkOutput("noDoneAfterReset", 64'(doneCount), 64'(savedDone));

      checkOutput("expAwLeft", 64'(expAw.size()), 64'd0);
      checkOutput("expArLeft", 64'(expAr.size()), 64'd0);
      checkOutput("expWLeft", 64'(expW.size()), 64'd0);
      checkOutput("expRdLeft", 64'(expRd.size()), 64'd0);
      checkOutput("expDoneLeft", 64'(expDone.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
